secure_reg_reader: RTL and testbench
====================================

# secure_reg_reader

Read-side responder for the bank of lock-protected configuration registers written by the team's lockable-register blocks. Accepts read requests over a valid/ready/ack handshake and checks each request against the register's lock status, a per-register secret mask, requester privilege, and debug/scan mode. It returns either the register value or an error with zeroed data. It also keeps a saturating count of denied reads and a sticky violation flag for the security monitor.

## Interface
- `NUM_REGS`, default 4: number of registers in the bank (≥2).
- `DATA_W`, default 32: register width.
- `SECRET_MASK`, default 'b0001: bit i=1 marks register i as secret.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `rd_req` in 1: read request; sampled only while `rd_ready`=1.
- `rd_addr` in $clog2(NUM_REGS): register index, sampled with `rd_req`.
- `rd_priv` in 1: requester is privileged, sampled with `rd_req`.
- `rd_ack` in 1: requester consumes the response.
- `reg_data` in NUM_REGS*DATA_W: flattened live register values; register i occupies bits [i*DATA_W +: DATA_W].
- `lock_status` in NUM_REGS: per-register lock bits from the writer blocks.
- `debug_mode` in 1: debug unlocked.
- `scan` in 1: scan mode active.
- `clr_cnt` in 1: clears `deny_cnt` and `violation`.
- `rd_ready` out 1: high only in IDLE.
- `rd_valid` out 1: response valid; held until `rd_ack`.
- `rd_data` out DATA_W: response data; 0 whenever `rd_err`=1.
- `rd_err` out 1: access denied or address out of range.
- `deny_cnt` out 8: saturating count of denied reads.
- `violation` out 1: sticky; set on any secret-register denial.

## Operation
- FSM states:
  - IDLE: `rd_ready`=1. `rd_req` latches addr and priv, then goes to CHECK.
  - CHECK: evaluates the policy and registers the verdict, then goes to FETCH.
  - FETCH: captures `reg_data` for the address, or 0 if denied, then goes to RESP.
  - RESP: `rd_valid`=1. `rd_ack` returns to IDLE.
- Policy, evaluated in CHECK; the first matching rule applies:
  - addr ≥ NUM_REGS → deny, not counted as a violation.
  - Secret register and (`debug_mode` | `scan`) → deny plus violation.
  - Secret register and !`rd_priv` → deny plus violation.
  - Secret register and !`lock_status[addr]` → deny plus violation, because secret values are readable only once committed.
  - All other cases → allow.
- Each deny increments `deny_cnt` once per transaction, in the CHECK→FETCH cycle. The count saturates at 255.
- If `debug_mode` or `scan` rises while in FETCH or RESP on an allowed secret read:
  - `rd_data` is cleared to 0 and `rd_err` is set on the next edge.
  - `deny_cnt` increments and `violation` is set, at most once per transaction.
  - `rd_valid` is unaffected.
- `clr_cnt` clears the counter and flag. If it coincides with an increment, `clr_cnt` wins.
- `reset`, including mid-transaction: state=IDLE, and every output is 0 except `rd_ready`=1. A pending response is discarded.

## Timing
- `rd_req` high in cycle 0 with `rd_ready`=1. The FSM is in CHECK in cycle 1 and FETCH in cycle 2. `rd_valid`, `rd_data` and `rd_err` are registered and valid from cycle 3.
- `rd_ack` high in cycle k ≥ 3: `rd_valid` and `rd_err` are low in cycle k+1, and `rd_data` returns to 0. `rd_ready`=1 in cycle k+1.
- `rd_ack` outside RESP is ignored. `rd_req` outside IDLE is ignored; there is no queueing.
- Minimum spacing between accepted requests is 4 cycles.
- `reg_data` and `lock_status` changes after FETCH do not alter `rd_data`.

## Structure
- Package `secure_reg_pkg`: state enum (IDLE, CHECK, FETCH, RESP), verdict enum (ALLOW, DENY_RANGE, DENY_SECRET), and the `DENY_CNT_MAX`=255 constant.
- Sub-module `secure_read_policy`: combinational verdict from addr, priv, lock, debug_mode, scan and SECRET_MASK. It is reused by the future write-side checker.
- The top level holds the FSM, the capture registers and the counter.

## Test plan
- Read reg 1 (non-secret) with `reg_data`[1]=32'hCAFE_0001 and no ack until cycle 5 → `rd_valid` is high in cycles 3–5 with `rd_data`=32'hCAFE_0001 and `rd_err`=0. `rd_ready` returns in cycle 6.
- Read reg 0 (secret) with lock=1, priv=1, debug=0 → data returned. Repeat with lock=0 → `rd_err`=1, `rd_data`=0, `deny_cnt`=1, `violation`=1.
- Read reg 0 with lock=1, priv=1, and `debug_mode` raised in cycle 3 before ack → `rd_data`=0 and `rd_err`=1 from cycle 4, with `deny_cnt` incremented once.
- Read address 5 with NUM_REGS=4 → `rd_err`=1, `violation` stays 0, `deny_cnt`=1.
- Issue 260 denied reads → `deny_cnt`=255. Then apply `clr_cnt` together with one further denial → `deny_cnt`=0 and `violation`=0.
- Assert `reset` in cycle 2 of a read → the next cycle shows IDLE with all outputs 0 except `rd_ready`=1. A later `rd_ack` has no effect.

Source files
------------

// File: rtl/secure_reg_pkg.sv
// Shared types for the secure register read path: FSM states, policy verdicts
// and the saturating deny counter helper.
package secure_reg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    FETCH = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ALLOW       = 2'd0,
    DENY_RANGE  = 2'd1,
    DENY_SECRET = 2'd2
  } verdict_e;

  localparam logic [7:0] DENY_CNT_MAX = 8'd255;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    if (v == DENY_CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/secure_read_policy.sv
// Combinational access verdict for one register index; shared by the read
// responder and the planned write-side checker.
module secure_read_policy
  import secure_reg_pkg::*;
#(
  parameter int                  NUM_REGS    = 4,
  parameter int                  ADDR_W      = $clog2(NUM_REGS),
  parameter logic [NUM_REGS-1:0] SECRET_MASK = {{(NUM_REGS-1){1'b0}}, 1'b1}
) (
  input  logic [ADDR_W-1:0]   addr,
  input  logic                priv,
  input  logic [NUM_REGS-1:0] lock,
  input  logic                debug_mode,
  input  logic                scan,
  output verdict_e            verdict,
  output logic                secret
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic [IDX_W-1:0] idx_s;
  assign idx_s = addr[IDX_W-1:0];

  // First matching rule wins; secret values need privilege, a committed lock
  // and neither debug nor scan access.
  always_comb begin
    verdict = ALLOW;
    secret  = 1'b0;
    if (32'(addr) >= 32'(NUM_REGS)) begin
      verdict = DENY_RANGE;
    end else begin
      secret = SECRET_MASK[idx_s];
      if (secret && (debug_mode || scan || !priv || !lock[idx_s])) begin
        verdict = DENY_SECRET;
      end else begin
        verdict = ALLOW;
      end
    end
  end

endmodule

// File: rtl/secure_reg_reader.sv
// Read-side responder for the lock-protected register bank: four-state
// request/check/fetch/respond FSM with a saturating deny counter.
module secure_reg_reader
  import secure_reg_pkg::*;
#(
  parameter int                  NUM_REGS    = 4,
  parameter int                  DATA_W      = 32,
  parameter logic [NUM_REGS-1:0] SECRET_MASK = {{(NUM_REGS-1){1'b0}}, 1'b1},
  parameter int                  ADDR_W      = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rd_req,
  input  logic [ADDR_W-1:0]          rd_addr,
  input  logic                       rd_priv,
  input  logic                       rd_ack,
  input  logic [NUM_REGS*DATA_W-1:0] reg_data,
  input  logic [NUM_REGS-1:0]        lock_status,
  input  logic                       debug_mode,
  input  logic                       scan,
  input  logic                       clr_cnt,
  output logic                       rd_ready,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_err,
  output logic [7:0]                 deny_cnt,
  output logic                       violation
);

  localparam int IDX_W = $clog2(NUM_REGS);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               priv_q, priv_d;
  verdict_e           verdict_q, verdict_d;
  logic               secret_q, secret_d;
  logic               revoked_q, revoked_d;
  logic               rd_ready_q, rd_ready_d;
  logic               rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               rd_err_q, rd_err_d;
  logic [7:0]         deny_cnt_q, deny_cnt_d;
  logic               violation_q, violation_d;

  verdict_e           verdict_s;
  logic               secret_s;
  logic               revoke_s;
  logic               inc_s;
  logic               viol_s;
  logic [IDX_W-1:0]   idx_s;

  secure_read_policy #(
    .NUM_REGS    (NUM_REGS),
    .ADDR_W      (ADDR_W),
    .SECRET_MASK (SECRET_MASK)
  ) u_policy (
    .addr       (addr_q),
    .priv       (priv_q),
    .lock       (lock_status),
    .debug_mode (debug_mode),
    .scan       (scan),
    .verdict    (verdict_s),
    .secret     (secret_s)
  );

  assign idx_s = addr_q[IDX_W-1:0];

  // An allowed secret read loses its data if debug or scan opens up before the requester acks.
  assign revoke_s = ((state_q == FETCH) || (state_q == RESP)) && (verdict_q == ALLOW) &&
                    secret_q && (debug_mode || scan) && !revoked_q;

  // Next-state, response capture and deny accounting.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    priv_d      = priv_q;
    verdict_d   = verdict_q;
    secret_d    = secret_q;
    revoked_d   = revoked_q;
    rd_ready_d  = rd_ready_q;
    rd_valid_d  = rd_valid_q;
    rd_data_d   = rd_data_q;
    rd_err_d    = rd_err_q;
    deny_cnt_d  = deny_cnt_q;
    violation_d = violation_q;
    inc_s       = 1'b0;
    viol_s      = 1'b0;

    case (state_q)
      IDLE: begin
        if (rd_req) begin
          addr_d     = rd_addr;
          priv_d     = rd_priv;
          rd_ready_d = 1'b0;
          state_d    = CHECK;
        end else begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        verdict_d = verdict_s;
        secret_d  = secret_s;
        revoked_d = 1'b0;
        inc_s     = (verdict_s != ALLOW);
        viol_s    = (verdict_s == DENY_SECRET);
        state_d   = FETCH;
      end
      FETCH: begin
        rd_valid_d = 1'b1;
        if ((verdict_q == ALLOW) && !revoke_s) begin
          rd_data_d = reg_data[idx_s*DATA_W +: DATA_W];
          rd_err_d  = 1'b0;
        end else begin
          rd_data_d = {DATA_W{1'b0}};
          rd_err_d  = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rd_ack) begin
          rd_valid_d = 1'b0;
          rd_err_d   = 1'b0;
          rd_data_d  = {DATA_W{1'b0}};
          rd_ready_d = 1'b1;
          state_d    = IDLE;
        end else if (revoke_s) begin
          rd_data_d = {DATA_W{1'b0}};
          rd_err_d  = 1'b1;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d    = IDLE;
        rd_ready_d = 1'b1;
        rd_valid_d = 1'b0;
        rd_err_d   = 1'b0;
        rd_data_d  = {DATA_W{1'b0}};
      end
    endcase

    if (revoke_s) begin
      revoked_d = 1'b1;
      inc_s     = 1'b1;
      viol_s    = 1'b1;
    end else begin
      revoked_d = revoked_d;
    end

    if (clr_cnt) begin
      deny_cnt_d  = 8'd0;
      violation_d = 1'b0;
    end else begin
      deny_cnt_d  = inc_s ? sat_inc(deny_cnt_q) : deny_cnt_q;
      violation_d = violation_q | viol_s;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= {ADDR_W{1'b0}};
      priv_q      <= 1'b0;
      verdict_q   <= ALLOW;
      secret_q    <= 1'b0;
      revoked_q   <= 1'b0;
      rd_ready_q  <= 1'b1;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= {DATA_W{1'b0}};
      rd_err_q    <= 1'b0;
      deny_cnt_q  <= 8'd0;
      violation_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      priv_q      <= priv_d;
      verdict_q   <= verdict_d;
      secret_q    <= secret_d;
      revoked_q   <= revoked_d;
      rd_ready_q  <= rd_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_err_q    <= rd_err_d;
      deny_cnt_q  <= deny_cnt_d;
      violation_q <= violation_d;
    end
  end

  assign rd_ready  = rd_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_err    = rd_err_q;
  assign deny_cnt  = deny_cnt_q;
  assign violation = violation_q;

endmodule

// File: tb/tb_secure_reg_reader.sv
// Self-checking bench for secure_reg_reader: vector table, hand-written
// corner sequences and random reads checked against a rule-level model.
module tb_secure_reg_reader;

  localparam int             NR    = 4;
  localparam int             DW    = 32;
  localparam int             AW    = 3;
  localparam logic [NR-1:0]  SMASK = 4'b0001;

  logic              clk = 1'b0;
  logic              reset, rd_req, rd_priv, rd_ack, debug_mode, scan, clr_cnt;
  logic [AW-1:0]     rd_addr;
  logic [NR*DW-1:0]  reg_data;
  logic [NR-1:0]     lock_status;
  logic              rd_ready, rd_valid, rd_err, violation;
  logic [DW-1:0]     rd_data;
  logic [7:0]        deny_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int m_cnt  = 0;
  bit m_viol = 1'b0;

  secure_reg_reader #(
    .NUM_REGS(NR), .DATA_W(DW), .SECRET_MASK(SMASK), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr), .rd_priv(rd_priv),
    .rd_ack(rd_ack), .reg_data(reg_data), .lock_status(lock_status),
    .debug_mode(debug_mode), .scan(scan), .clr_cnt(clr_cnt), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err), .deny_cnt(deny_cnt),
    .violation(violation)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           addr;
    bit           priv;
    logic [NR-1:0] lock;
    bit           dbg;
    bit           sc;
    int           hold;
    bit           exp_err;
    bit           exp_viol;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] reg_of(input int a);
    return reg_data[a*DW +: DW];
  endfunction

  // Access rules stated directly: range first, then the secret-register conditions.
  function automatic void ref_policy(input int a, input bit priv, input logic [NR-1:0] lk,
                                     input bit dbg, input bit sc, output bit err, output bit viol);
    err  = 1'b0;
    viol = 1'b0;
    if (a >= NR) begin
      err = 1'b1;
    end else if (SMASK[a] && (dbg || sc || !priv || !lk[a])) begin
      err  = 1'b1;
      viol = 1'b1;
    end
  endfunction

  task automatic model_deny(input bit viol);
    if (m_cnt < 255) m_cnt++;
    if (viol) m_viol = 1'b1;
  endtask

  task automatic set_base_regs;
    reg_data = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
  endtask

  task automatic check_idle(input string tag);
    check({tag, " ready"}, rd_ready, 1);
    check({tag, " valid"}, rd_valid, 0);
    check({tag, " err"},   rd_err, 0);
    check({tag, " data"},  rd_data, 0);
  endtask

  task automatic read_txn(input string tag, input int a, input bit priv, input logic [NR-1:0] lk,
                          input bit dbg, input bit sc, input int hold,
                          input bit exp_err, input bit exp_viol);
    logic [DW-1:0] exp_data;
    check({tag, " ready"}, rd_ready, 1);
    rd_req = 1'b1; rd_addr = AW'(a); rd_priv = priv;
    lock_status = lk; debug_mode = dbg; scan = sc;
    if (exp_err) begin
      exp_data = '0;
      model_deny(exp_viol);
    end else begin
      exp_data = reg_of(a);
    end
    tick;
    rd_req = 1'b0;
    tick;
    check({tag, " early valid"}, rd_valid, 0);
    tick;
    for (int c = 0; c < hold; c++) begin
      check({tag, " valid"}, rd_valid, 1);
      check({tag, " ready low"}, rd_ready, 0);
      check({tag, " data"}, rd_data, exp_data);
      check({tag, " err"}, rd_err, exp_err);
      check({tag, " cnt"}, deny_cnt, m_cnt);
      check({tag, " viol"}, violation, m_viol);
      if (c == 0) begin
        reg_data    = {$urandom, $urandom, $urandom, $urandom};
        lock_status = NR'($urandom);
      end
      if (c == hold - 1) rd_ack = 1'b1;
      tick;
    end
    rd_ack = 1'b0;
    check_idle({tag, " after ack"});
  endtask

  initial begin
    bit e, v;
    int a;
    reset = 1'b1; rd_req = 1'b0; rd_priv = 1'b0; rd_ack = 1'b0; debug_mode = 1'b0;
    scan = 1'b0; clr_cnt = 1'b0; rd_addr = '0; lock_status = '0;
    set_base_regs();

    vecs[0] = '{1, 1'b0, 4'h0, 1'b0, 1'b0, 3, 1'b0, 1'b0};
    vecs[1] = '{5, 1'b1, 4'hF, 1'b0, 1'b0, 1, 1'b1, 1'b0};
    vecs[2] = '{0, 1'b1, 4'h1, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    vecs[3] = '{0, 1'b1, 4'hE, 1'b0, 1'b0, 1, 1'b1, 1'b1};
    vecs[4] = '{0, 1'b0, 4'hF, 1'b0, 1'b0, 2, 1'b1, 1'b1};
    vecs[5] = '{0, 1'b1, 4'hF, 1'b1, 1'b0, 1, 1'b1, 1'b1};
    vecs[6] = '{0, 1'b1, 4'hF, 1'b0, 1'b1, 1, 1'b1, 1'b1};
    vecs[7] = '{2, 1'b0, 4'h0, 1'b1, 1'b1, 1, 1'b0, 1'b0};
    vecs[8] = '{3, 1'b1, 4'hF, 1'b0, 1'b0, 2, 1'b0, 1'b0};
    vecs[9] = '{7, 1'b0, 4'h0, 1'b1, 1'b0, 1, 1'b1, 1'b0};

    @(negedge clk);
    tick;
    reset = 1'b0;
    check_idle("reset");
    check("reset cnt", deny_cnt, 0);
    check("reset viol", violation, 0);

    for (int i = 0; i < 10; i++) begin
      set_base_regs();
      read_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].priv, vecs[i].lock, vecs[i].dbg,
               vecs[i].sc, vecs[i].hold, vecs[i].exp_err, vecs[i].exp_viol);
    end

    // Debug opens up while an allowed secret response is pending.
    set_base_regs();
    check("rev ready", rd_ready, 1);
    rd_req = 1'b1; rd_addr = 3'd0; rd_priv = 1'b1; lock_status = 4'hF;
    debug_mode = 1'b0; scan = 1'b0;
    tick; rd_req = 1'b0;
    tick;
    tick;
    check("rev c3 data", rd_data, 32'hCAFE_0000);
    check("rev c3 err", rd_err, 0);
    debug_mode = 1'b1;
    tick;
    model_deny(1'b1);
    check("rev c4 valid", rd_valid, 1);
    check("rev c4 data", rd_data, 0);
    check("rev c4 err", rd_err, 1);
    check("rev c4 cnt", deny_cnt, m_cnt);
    check("rev c4 viol", violation, 1);
    tick;
    check("rev c5 cnt once", deny_cnt, m_cnt);
    check("rev c5 err", rd_err, 1);
    debug_mode = 1'b0;
    rd_ack = 1'b1;
    tick;
    rd_ack = 1'b0;
    check_idle("rev done");

    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(0, 7));
      reg_data = {$urandom, $urandom, $urandom, $urandom};
      rd_priv = 1'($urandom);
      lock_status = NR'($urandom);
      debug_mode = ($urandom_range(0, 3) == 0);
      scan = ($urandom_range(0, 3) == 0);
      ref_policy(a, rd_priv, lock_status, debug_mode, scan, e, v);
      read_txn($sformatf("rnd%0d", i), a, rd_priv, lock_status, debug_mode, scan,
               int'($urandom_range(1, 3)), e, v);
    end

    for (int i = 0; i < 260; i++) begin
      read_txn("sat", 4, 1'b0, 4'h0, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    end
    check("sat cnt", deny_cnt, 255);

    // Clear coinciding with a further secret denial.
    check("clr ready", rd_ready, 1);
    rd_req = 1'b1; rd_addr = 3'd0; rd_priv = 1'b0; lock_status = 4'hF;
    debug_mode = 1'b0; scan = 1'b0;
    tick;
    rd_req = 1'b0;
    clr_cnt = 1'b1;
    tick;
    clr_cnt = 1'b0;
    m_cnt = 0; m_viol = 1'b0;
    check("clr cnt", deny_cnt, 0);
    check("clr viol", violation, 0);
    tick;
    check("clr resp err", rd_err, 1);
    check("clr resp data", rd_data, 0);
    rd_ack = 1'b1;
    tick;
    rd_ack = 1'b0;
    check_idle("clr done");

    // Reset in the middle of a denied read.
    rd_req = 1'b1; rd_addr = 3'd0; rd_priv = 1'b0; lock_status = 4'hF;
    tick;
    rd_req = 1'b0;
    tick;
    check("mid cnt before reset", deny_cnt, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    m_cnt = 0; m_viol = 1'b0;
    check_idle("mid reset");
    check("mid reset cnt", deny_cnt, 0);
    check("mid reset viol", violation, 0);
    rd_ack = 1'b1;
    tick;
    rd_ack = 1'b0;
    check_idle("stale ack");
    set_base_regs();
    read_txn("post reset", 1, 1'b1, 4'h0, 1'b0, 1'b0, 1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
